// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with branch/jump redirect, wrong-path flush, misalign flag and redirect counter
module pc_redirect_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ExValid,
    input  logic             PCASrc,
    input  logic             PCBSrc,
    input  logic [XLEN-1:0]  ExPC,
    input  logic [XLEN-1:0]  ExImm,
    input  logic [XLEN-1:0]  ExRs1,
    input  logic             Stall,
    output logic [XLEN-1:0]  PC,
    output logic             IFFlush,
    output logic             IDFlush,
    output logic             Redirect,
    output logic             MisalignErr,
    output logic [CNT_W-1:0] RedirectCnt
);
    typedef enum logic {IDLE, FLUSH} state_t;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);
    state_t state;
    logic [1:0] flush_cnt;
    logic [XLEN-1:0] sum, tgt;
    logic take;
    always_comb begin
        sum  = (PCASrc ? ExImm : FOUR) + (PCBSrc ? ExRs1 : ExPC);
        tgt  = {sum[XLEN-1:1], sum[0] & ~PCBSrc};
        take = ExValid & (PCASrc | PCBSrc) & (state == IDLE);
    end
    assign IDFlush = IFFlush;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            PC          <= RESET_PC;
            IFFlush     <= 1'b0;
            Redirect    <= 1'b0;
            MisalignErr <= 1'b0;
            RedirectCnt <= '0;
        end else begin
            PC       <= take ? tgt : Stall ? PC : PC + FOUR;
            Redirect <= take;
            IFFlush  <= (state == IDLE) ? take : (flush_cnt != 2'd0);
            if (take && tgt[1])
                MisalignErr <= 1'b1;
            if (take && RedirectCnt != '1)
                RedirectCnt <= RedirectCnt + 1'b1;
            if (state == IDLE) begin
                if (take) begin
                    state     <= FLUSH;
                    flush_cnt <= 2'(FLUSH_CYCLES - 1);
                end
            end else if (flush_cnt == 2'd0)
                state <= IDLE;
            else
                flush_cnt <= flush_cnt - 2'd1;
        end
    end
endmodule
